// File: rtl/vector_line_draw.sv
// Vector beam line drawer: accepts a segment, settles on the start point, then
// walks the Bresenham points toward the end point, holding each for STEP_DIV cycles.
module vector_line_draw #(
  parameter int unsigned STEP_DIV   = 40,
  parameter int unsigned SETTLE_CYC = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       seg_valid,
  output logic       seg_ready,
  input  logic [7:0] seg_x0,
  input  logic [7:0] seg_y0,
  input  logic [7:0] seg_x1,
  input  logic [7:0] seg_y1,
  output logic [7:0] xch,
  output logic [7:0] ych,
  output logic       pt_strobe,
  output logic       busy
);

  localparam logic [15:0] SETTLE_LD = 16'(SETTLE_CYC - 1);
  localparam logic [15:0] STEP_LD   = 16'(STEP_DIV - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, DRAW} state_t;

  state_t             state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [7:0]         x_q, x_d, y_q, y_d;
  logic [7:0]         xe_q, xe_d, ye_q, ye_d;
  logic signed [11:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
  logic signed [11:0] e2;
  logic               sx_q, sx_d, sy_q, sy_d;
  logic               strobe_q, strobe_d;
  logic [7:0]         adx, ady;

  function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Coordinates only ever move toward the end point, so this never wraps.
  function automatic logic [7:0] step_coord(input logic [7:0] c, input logic up);
    return up ? (c + 8'd1) : (c - 8'd1);
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    y_d      = y_q;
    xe_d     = xe_q;
    ye_d     = ye_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    err_d    = err_q;
    sx_d     = sx_q;
    sy_d     = sy_q;
    strobe_d = 1'b0;
    adx      = abs_diff(seg_x1, seg_x0);
    ady      = abs_diff(seg_y1, seg_y0);
    e2       = err_q <<< 1;
    case (state_q)
      IDLE: begin
        if (seg_valid) begin
          state_d = SETTLE;
          cnt_d   = SETTLE_LD;
          x_d     = seg_x0;
          y_d     = seg_y0;
          xe_d    = seg_x1;
          ye_d    = seg_y1;
          dx_d    = signed'({4'b0000, adx});
          dy_d    = -signed'({4'b0000, ady});
          sx_d    = (seg_x1 >= seg_x0);
          sy_d    = (seg_y1 >= seg_y0);
          err_d   = signed'({4'b0000, adx}) - signed'({4'b0000, ady});
        end
      end
      SETTLE: begin
        if (cnt_q == 16'd0) begin
          state_d  = DRAW;
          cnt_d    = STEP_LD;
          strobe_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DRAW: begin
        if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
        end else if ((x_q == xe_q) && (y_q == ye_q)) begin
          state_d = IDLE;
        end else begin
          // Both axis updates use the same e2 and may apply in one step.
          if (e2 >= dy_q) begin
            err_d = err_d + dy_q;
            x_d   = step_coord(x_q, sx_q);
          end
          if (e2 <= dx_q) begin
            err_d = err_d + dx_q;
            y_d   = step_coord(y_q, sy_q);
          end
          cnt_d    = STEP_LD;
          strobe_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    xe_q  <= xe_d;
    ye_q  <= ye_d;
    dx_q  <= dx_d;
    dy_q  <= dy_d;
    err_q <= err_d;
    sx_q  <= sx_d;
    sy_q  <= sy_d;
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 16'd0;
      x_q      <= 8'h80;
      y_q      <= 8'h80;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      strobe_q <= strobe_d;
    end
  end

  assign xch       = x_q;
  assign ych       = y_q;
  assign pt_strobe = strobe_q;
  assign seg_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_vector_line_draw.sv
// Bench for vector_line_draw: directed and random segments checked cycle by cycle
// against a point-list reference model.
module tb_vector_line_draw;
  localparam int STEP = 4;
  localparam int SETL = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       seg_valid;
  logic       seg_ready;
  logic [7:0] seg_x0, seg_y0, seg_x1, seg_y1;
  logic [7:0] xch, ych;
  logic       pt_strobe;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int ex[$];
  int ey[$];

  always #5 clk = ~clk;

  vector_line_draw #(.STEP_DIV(STEP), .SETTLE_CYC(SETL)) dut (
    .clk(clk), .rst(rst), .seg_valid(seg_valid), .seg_ready(seg_ready),
    .seg_x0(seg_x0), .seg_y0(seg_y0), .seg_x1(seg_x1), .seg_y1(seg_y1),
    .xch(xch), .ych(ych), .pt_strobe(pt_strobe), .busy(busy)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Whole point list of a segment from the line rule, as plain integers.
  task automatic build_line(input int x0, input int y0, input int x1, input int y1);
    int dx, dy, sx, sy, err, e2, x, y;
    ex.delete();
    ey.delete();
    dx = iabs(x1 - x0);
    dy = -iabs(y1 - y0);
    sx = (x1 >= x0) ? 1 : -1;
    sy = (y1 >= y0) ? 1 : -1;
    err = dx + dy;
    x = x0;
    y = y0;
    for (int guard = 0; guard < 600; guard++) begin
      ex.push_back(x);
      ey.push_back(y);
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endtask

  // Entered and left on a negedge while the DUT is idle; expected points in ex/ey.
  task automatic run_segment(input int x0, input int y0, input int x1, input int y1,
                             input bit poke);
    int busy_cnt, exp_n;
    busy_cnt = 0;
    exp_n = ((iabs(x1 - x0) > iabs(y1 - y0)) ? iabs(x1 - x0) : iabs(y1 - y0)) + 1;
    check("ready_pre", int'(seg_ready), 1);
    check("busy_pre", int'(busy), 0);
    seg_valid = 1'b1;
    seg_x0 = 8'(x0); seg_y0 = 8'(y0); seg_x1 = 8'(x1); seg_y1 = 8'(y1);
    @(posedge clk);
    #1;
    seg_valid = poke;
    if (poke) begin
      seg_x0 = 8'($urandom); seg_y0 = 8'($urandom);
      seg_x1 = 8'($urandom); seg_y1 = 8'($urandom);
    end
    for (int c = 0; c < SETL; c++) begin
      @(negedge clk);
      busy_cnt += int'(busy);
      check("settle_x", int'(xch), x0);
      check("settle_y", int'(ych), y0);
      check("settle_strobe", int'(pt_strobe), 0);
      check("settle_ready", int'(seg_ready), 0);
    end
    for (int i = 0; i < ex.size(); i++) begin
      for (int k = 0; k < STEP; k++) begin
        @(negedge clk);
        busy_cnt += int'(busy);
        check("draw_x", int'(xch), ex[i]);
        check("draw_y", int'(ych), ey[i]);
        check("draw_strobe", int'(pt_strobe), (k == 0) ? 1 : 0);
      end
    end
    @(negedge clk);
    seg_valid = 1'b0;
    check("idle_busy", int'(busy), 0);
    check("idle_ready", int'(seg_ready), 1);
    check("idle_strobe", int'(pt_strobe), 0);
    check("end_x", int'(xch), x1);
    check("end_y", int'(ych), y1);
    check("busy_cycles", busy_cnt, SETL + STEP * exp_n);
  endtask

  initial begin
    rst = 1'b1;
    seg_valid = 1'b0;
    seg_x0 = 8'd0; seg_y0 = 8'd0; seg_x1 = 8'd0; seg_y1 = 8'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_x", int'(xch), 8'h80);
    check("rst_y", int'(ych), 8'h80);
    check("rst_ready", int'(seg_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_strobe", int'(pt_strobe), 0);

    ex = '{10, 11, 12, 13};
    ey = '{10, 10, 10, 10};
    run_segment(10, 10, 13, 10, 1'b0);

    ex = '{0, 1, 1, 2, 2, 3};
    ey = '{0, 1, 2, 3, 4, 5};
    run_segment(0, 0, 3, 5, 1'b0);

    ex.delete();
    ey.delete();
    for (int i = 0; i < 256; i++) begin
      ex.push_back(255 - i);
      ey.push_back(i);
    end
    run_segment(255, 0, 0, 255, 1'b0);

    ex = '{50};
    ey = '{50};
    run_segment(50, 50, 50, 50, 1'b1);

    // Abort in the middle of drawing.
    seg_valid = 1'b1;
    seg_x0 = 8'd20; seg_y0 = 8'd30; seg_x1 = 8'd90; seg_y1 = 8'd35;
    @(posedge clk);
    #1;
    seg_valid = 1'b0;
    repeat (SETL + 6) @(negedge clk);
    check("abort_busy_before", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_x", int'(xch), 8'h80);
    check("abort_y", int'(ych), 8'h80);
    check("abort_busy", int'(busy), 0);
    check("abort_ready", int'(seg_ready), 1);
    check("abort_strobe", int'(pt_strobe), 0);
    rst = 1'b0;
    @(negedge clk);
    build_line(7, 200, 1, 190);
    run_segment(7, 200, 1, 190, 1'b0);

    for (int r = 0; r < 12; r++) begin
      int a, b, c, d;
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      if (r < 6) begin
        c = $urandom_range(0, 255);
        d = $urandom_range(0, 255);
      end else begin
        c = (a + $urandom_range(0, 20)) % 256;
        d = (b + 256 - $urandom_range(0, 20)) % 256;
      end
      build_line(a, b, c, d);
      run_segment(a, b, c, d, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
